vfifo_sc_ctrl: RTL and testbench

// Synchronous single-clock FIFO controller that sequences vfifo_dual_port_ram_sc_sw.
// - Owns the RAM's write port (we_a, adr_a) and read address (adr_b).
// - Keeps read/write pointers, fill count, full/empty/almost flags and error pulses.
// - The RAM's data ports (d_a, q_b) connect directly to the user; this block handles control only.

---
 rtl/vfifo_sc_ctrl.sv | 64 ++++++
 tb/tb_vfifo_sc_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/vfifo_sc_ctrl.sv
// vfifo_sc_ctrl: single-clock FIFO controller sequencing a dual-port RAM (pointers, count, flags, error pulses)
module vfifo_sc_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_adr_a,
  output logic [ADDR_WIDTH-1:0] ram_adr_b,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE    = (ADDR_WIDTH+1)'(AE_LEVEL);
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  wr_acc, rd_acc;
  always_comb begin
    wr_acc    = wr_en & ~full;
    rd_acc    = rd_en & ~empty;
    count_nxt = (wr_acc & ~rd_acc) ? count + (ADDR_WIDTH+1)'(1) :
                (rd_acc & ~wr_acc) ? count - (ADDR_WIDTH+1)'(1) : count;
  end
  assign ram_we_a  = wr_acc;
  assign ram_adr_a = wr_ptr;
  assign ram_adr_b = rd_ptr;
  // flags come from count_nxt so they never lag the count register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      rd_valid     <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_acc ? wr_ptr + ADDR_WIDTH'(1) : wr_ptr;
      rd_ptr       <= rd_acc ? rd_ptr + ADDR_WIDTH'(1) : rd_ptr;
      count        <= count_nxt;
      empty        <= count_nxt == '0;
      full         <= count_nxt == DEPTH;
      almost_full  <= count_nxt >= AF;
      almost_empty <= count_nxt <= AE;
      rd_valid     <= rd_acc;
      overflow     <= wr_en & full;
      underflow    <= rd_en & empty;
    end
  end
endmodule

// File: tb/tb_vfifo_sc_ctrl.sv
// tb_vfifo_sc_ctrl: directed bench for vfifo_sc_ctrl with a behavioural registered-read RAM beside it
module tb_vfifo_sc_ctrl;
  logic       clk = 0, rst = 1, wr_en = 0, rd_en = 0;
  logic       ram_we_a, rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] ram_adr_a, ram_adr_b, adr_b_q;
  logic [4:0] count;
  logic [7:0] d_a = 0, q_b;
  logic [7:0] mem [16];
  int errors = 0, checks = 0;

  vfifo_sc_ctrl #(.ADDR_WIDTH(4), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .ram_we_a(ram_we_a), .ram_adr_a(ram_adr_a), .ram_adr_b(ram_adr_b),
    .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_adr_a] <= d_a;
    adr_b_q <= ram_adr_b;
  end
  assign q_b = mem[adr_b_q];

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; cyc(); cyc(); rst = 0; #1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if ({empty, almost_empty, full, almost_full, rd_valid, overflow, underflow, ram_we_a} !== 8'b1100_0000)
      begin errors++; $display("FAIL reset_flags got %b exp 11000000", {empty, almost_empty, full, almost_full, rd_valid, overflow, underflow, ram_we_a}); end
    cyc();
    checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL idle got count=%0d empty=%b exp 0/1", count, empty); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; d_a = 8'(i); #1;
      checks++; if (ram_we_a !== 1'b1 || ram_adr_a !== 4'(i)) begin errors++; $display("FAIL fill_adr got we=%b adr=%0d exp 1/%0d", ram_we_a, ram_adr_a, i); end
      cyc();
      checks++; if (count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count got %0d exp %0d", count, i + 1); end
      checks++; if (almost_full !== (i + 1 >= 12)) begin errors++; $display("FAIL fill_af got %b at count %0d", almost_full, i + 1); end
      checks++; if (full !== (i == 15) || empty !== 1'b0) begin errors++; $display("FAIL fill_full got full=%b empty=%b at count %0d", full, empty, i + 1); end
    end
    #1;
    checks++; if (ram_we_a !== 1'b0) begin errors++; $display("FAIL over_we got %b exp 0", ram_we_a); end
    cyc(); wr_en = 0;
    checks++; if (overflow !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL overflow got ovf=%b count=%0d exp 1/16", overflow, count); end
    cyc();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_pulse got %b exp 0", overflow); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      rd_en = 1; #1;
      checks++; if (ram_adr_b !== 4'(i)) begin errors++; $display("FAIL drain_adr got %0d exp %0d", ram_adr_b, i); end
      cyc();
      checks++; if (rd_valid !== 1'b1 || q_b !== 8'(i)) begin errors++; $display("FAIL drain_data got v=%b q=%0d exp 1/%0d", rd_valid, q_b, i); end
      checks++; if (count !== 5'(15 - i) || almost_empty !== (15 - i <= 2)) begin errors++; $display("FAIL drain_count got %0d ae=%b exp %0d", count, almost_empty, 15 - i); end
    end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL drain_empty got empty=%b full=%b exp 1/0", empty, full); end
    cyc(); rd_en = 0;
    checks++; if (underflow !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL underflow got uf=%b v=%b exp 1/0", underflow, rd_valid); end
    cyc();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_pulse got %b exp 0", underflow); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 8; k++) begin wr_en = 1; d_a = 8'(100 + k); cyc(); end
    for (int k = 0; k < 40; k++) begin
      wr_en = 1; rd_en = 1; d_a = 8'(108 + k); cyc();
      checks++; if (count !== 5'd8 || rd_valid !== 1'b1 || q_b !== 8'(100 + k))
        begin errors++; $display("FAIL wrap got count=%0d v=%b q=%0d exp 8/1/%0d", count, rd_valid, q_b, 100 + k); end
    end
    rd_en = 0;
    for (int k = 0; k < 8; k++) begin d_a = 8'(148 + k); cyc(); end
    wr_en = 0;
    checks++; if (full !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL wrap_full got full=%b count=%0d exp 1/16", full, count); end
  endtask

  task automatic test_simultaneous();
    wr_en = 1; rd_en = 1; d_a = 8'hEE; cyc(); wr_en = 0; rd_en = 0;
    checks++; if (count !== 5'd15 || overflow !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b1 || q_b !== 8'd140)
      begin errors++; $display("FAIL sim_full got count=%0d ovf=%b full=%b v=%b q=%0d exp 15/1/0/1/140", count, overflow, full, rd_valid, q_b); end
    rd_en = 1;
    for (int k = 0; k < 15; k++) cyc();
    checks++; if (empty !== 1'b1 || q_b !== 8'd155) begin errors++; $display("FAIL sim_drain got empty=%b q=%0d exp 1/155", empty, q_b); end
    wr_en = 1; d_a = 8'h5A; cyc(); wr_en = 0; rd_en = 0;
    checks++; if (count !== 5'd1 || underflow !== 1'b1 || rd_valid !== 1'b0 || empty !== 1'b0)
      begin errors++; $display("FAIL sim_empty got count=%0d uf=%b v=%b empty=%b exp 1/1/0/0", count, underflow, rd_valid, empty); end
    rd_en = 1; cyc(); rd_en = 0;
    checks++; if (rd_valid !== 1'b1 || q_b !== 8'h5A || empty !== 1'b1) begin errors++; $display("FAIL sim_readback got v=%b q=%0d empty=%b exp 1/90/1", rd_valid, q_b, empty); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) begin wr_en = 1; d_a = 8'(200 + k); cyc(); end
    wr_en = 0;
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL mid_pre got %0d exp 5", count); end
    rd_en = 1; rst = 1; cyc(); rst = 0; rd_en = 0;
    checks++; if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || almost_empty !== 1'b1)
      begin errors++; $display("FAIL mid_reset got count=%0d empty=%b v=%b ae=%b exp 0/1/0/1", count, empty, rd_valid, almost_empty); end
    wr_en = 1; d_a = 8'hAB; #1;
    checks++; if (ram_adr_a !== 4'd0) begin errors++; $display("FAIL mid_wadr got %0d exp 0", ram_adr_a); end
    cyc(); wr_en = 0; rd_en = 1; cyc(); rd_en = 0;
    checks++; if (rd_valid !== 1'b1 || q_b !== 8'hAB || count !== 5'd0) begin errors++; $display("FAIL mid_readback got v=%b q=%0d count=%0d exp 1/171/0", rd_valid, q_b, count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
